// File: rtl/uart_pkg.sv
// Shared definitions for the uart_top register-bus host: register map, sequencer states, frame timing.
package uart_pkg;

  localparam logic [1:0] UART_ADDR_BAUD   = 2'd0;
  localparam logic [1:0] UART_ADDR_ENABLE = 2'd1;
  localparam logic [1:0] UART_ADDR_TX     = 2'd2;
  localparam logic [1:0] UART_ADDR_RX     = 2'd3;

  // 10-bit frame plus one guard bit-time between transmitted bytes
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [3:0] {
    IDLE,
    CFG_DIS,
    CFG_BAUD,
    CFG_EN,
    READY,
    TX_WR,
    TX_HOLD,
    RD_ISSUE,
    RD_CAP
  } uart_state_e;

  function automatic logic [35:0] frame_hold_init(input logic [31:0] div);
    return (36'(div) * 36'(UART_FRAME_BITS)) - 36'd1;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, history updated on the advance strobe.
// A tie goes to the requester that did not win last; reset favours requester 0.
module uart_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = i_valid;
    if (&i_valid) begin
      o_grant = r_last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
    end else if (i_advance) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// Owns the uart_top register bus: config sequence, round-robin TX with per-byte frame hold, RX reads.
// Bus outputs are registered one cycle after the decision; requester readies are combinational.
module uart_host_ctrl
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_div,
  input  logic        cfg_start,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        cfg_ok,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        rd_req,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic [1:0]  address,
  output logic [31:0] write_data,
  output logic        we,
  output logic        re,
  input  logic [7:0]  read_data
);

  uart_state_e r_state;
  uart_state_e w_nxt_state;

  logic        r_cfg_pend;
  logic [31:0] r_pend_div;
  logic [31:0] r_div;
  logic [35:0] r_hold;

  logic        w_cfg_req;
  logic [31:0] w_cfg_div;
  logic        w_cfg_open;
  logic        w_cfg_bad;
  logic [1:0]  w_grant;
  logic        w_rdy_base;
  logic        w_accept;
  logic [7:0]  w_tx_byte;
  logic        w_we;
  logic        w_re;
  logic [1:0]  w_addr;
  logic [31:0] w_wdata;

  // A cfg_start arriving while busy is remembered and served once back in READY
  assign w_cfg_req  = cfg_start | r_cfg_pend;
  assign w_cfg_div  = cfg_start ? cfg_div : r_pend_div;
  assign w_cfg_open = (r_state == IDLE) || (r_state == READY);
  assign w_cfg_bad  = w_cfg_open & w_cfg_req & (w_cfg_div == 32'd0);

  assign w_rdy_base = (r_state == READY) & ~w_cfg_req & ~rd_req;
  assign req0_ready = w_rdy_base & w_grant[0];
  assign req1_ready = w_rdy_base & w_grant[1];
  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_tx_byte  = w_grant[1] ? req1_data : req0_data;

  uart_rr_arb u_arb (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   ({req1_valid, req0_valid}),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_addr      = UART_ADDR_BAUD;
    w_wdata     = 32'd0;

    case (r_state)
      IDLE:     if (w_cfg_req && !w_cfg_bad) w_nxt_state = CFG_DIS;
      CFG_DIS:  w_nxt_state = CFG_BAUD;
      CFG_BAUD: w_nxt_state = CFG_EN;
      CFG_EN:   w_nxt_state = READY;
      READY: begin
        if (w_cfg_req) begin
          if (!w_cfg_bad) w_nxt_state = CFG_DIS;
        end else if (rd_req) begin
          w_nxt_state = RD_ISSUE;
        end else if (w_accept) begin
          w_nxt_state = TX_WR;
        end
      end
      TX_WR:    w_nxt_state = TX_HOLD;
      TX_HOLD:  if (r_hold == '0) w_nxt_state = READY;
      RD_ISSUE: w_nxt_state = RD_CAP;
      RD_CAP:   w_nxt_state = READY;
      default:  w_nxt_state = IDLE;
    endcase

    // Bus drive is decoded from the state being entered so it lands registered in that state
    case (w_nxt_state)
      CFG_DIS: begin
        w_we   = 1'b1;
        w_addr = UART_ADDR_ENABLE;
      end
      CFG_BAUD: begin
        w_we    = 1'b1;
        w_addr  = UART_ADDR_BAUD;
        w_wdata = r_div;
      end
      CFG_EN: begin
        w_we    = 1'b1;
        w_addr  = UART_ADDR_ENABLE;
        w_wdata = 32'd1;
      end
      TX_WR: begin
        w_we    = 1'b1;
        w_addr  = UART_ADDR_TX;
        w_wdata = {24'd0, w_tx_byte};
      end
      RD_ISSUE: begin
        w_re   = 1'b1;
        w_addr = UART_ADDR_RX;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_pend <= 1'b0;
      r_pend_div <= 32'd0;
      r_div      <= 32'd0;
    end else begin
      if (w_cfg_open) begin
        r_cfg_pend <= 1'b0;
      end else if (cfg_start) begin
        r_cfg_pend <= 1'b1;
        r_pend_div <= cfg_div;
      end
      if (w_nxt_state == CFG_DIS) r_div <= w_cfg_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_state == TX_WR) begin
      r_hold <= frame_hold_init(r_div);
    end else if (r_state == TX_HOLD && r_hold != '0) begin
      r_hold <= r_hold - 36'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we         <= 1'b0;
      re         <= 1'b0;
      address    <= 2'd0;
      write_data <= 32'd0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ok     <= 1'b0;
      busy       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'd0;
    end else begin
      we         <= w_we;
      re         <= w_re;
      address    <= w_addr;
      write_data <= w_wdata;
      cfg_done   <= (w_nxt_state == CFG_EN);
      cfg_err    <= w_cfg_bad;
      busy       <= (w_nxt_state != IDLE) && (w_nxt_state != READY);
      rd_valid   <= (r_state == RD_CAP);
      if (r_state == RD_CAP) rd_data <= read_data;
      if (w_nxt_state == CFG_DIS) begin
        cfg_ok <= 1'b0;
      end else if (w_nxt_state == CFG_EN) begin
        cfg_ok <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Randomized scoreboard bench for uart_host_ctrl: stimulus tasks predict bus, read, control and
// accept events from the timing rules; a negedge monitor pops and compares every event the DUT shows.
module tb_uart_host_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_div = 32'd0;
  logic        cfg_start = 1'b0;
  logic        cfg_done, cfg_err, cfg_ok;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = 8'd0, req1_data = 8'd0;
  logic        req0_ready, req1_ready;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_valid, busy;
  logic [1:0]  address;
  logic [31:0] write_data;
  logic        we, re;
  logic [7:0]  read_data;

  uart_host_ctrl dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_start(cfg_start),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_ok(cfg_ok),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .address(address), .write_data(write_data), .we(we), .re(re),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t q_bus[$];
  ev_t q_rd[$];
  ev_t q_ctl[$];
  ev_t q_acc[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int m_last = 1;
  int m_div = 0;
  logic [7:0] rx_val = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // RX register of the uart: answers one cycle after re, noise otherwise
  always @(posedge clk) read_data <= re ? rx_val : 8'($urandom);

  function automatic logic [31:0] busv(input logic w, input logic r, input logic [1:0] ad);
    return {28'd0, w, r, ad};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.cyc = c;
    e.a = a;
    e.b = b;
    case (k)
      0: q_bus.push_back(e);
      1: q_rd.push_back(e);
      2: q_ctl.push_back(e);
      default: q_acc.push_back(e);
    endcase
  endtask

  task automatic observe(input int k, input string nm, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    bit have;
    have = 1'b0;
    case (k)
      0: if (q_bus.size() > 0) begin e = q_bus.pop_front(); have = 1'b1; end
      1: if (q_rd.size() > 0) begin e = q_rd.pop_front(); have = 1'b1; end
      2: if (q_ctl.size() > 0) begin e = q_ctl.pop_front(); have = 1'b1; end
      default: if (q_acc.size() > 0) begin e = q_acc.pop_front(); have = 1'b1; end
    endcase
    n_chk++;
    if (!have) begin
      n_err++;
      $display("FAIL %s: unexpected event a=%0h b=%0h at cycle %0d", nm, a, b, cyc);
    end else if (e.cyc != cyc || e.a !== a || e.b !== b) begin
      n_err++;
      $display("FAIL %s: got cycle %0d a=%0h b=%0h, expected cycle %0d a=%0h b=%0h",
               nm, cyc, a, b, e.cyc, e.a, e.b);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (we || re) observe(0, "bus", busv(we, re, address), write_data);
      else chk("idle_bus", {30'd0, address, write_data}, 64'd0);
      if (rd_valid) observe(1, "rd", 32'd0, {24'd0, rd_data});
      if (cfg_done || cfg_err) observe(2, "ctl", {30'd0, cfg_done, cfg_err}, 32'd0);
      if (req0_valid && req0_ready) observe(3, "acc0", 32'd0, {24'd0, req0_data});
      if (req1_valid && req1_ready) observe(3, "acc1", 32'd1, {24'd0, req1_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_cfg(input logic [31:0] d);
    int n;
    n = cyc;
    cfg_div = d;
    cfg_start = 1'b1;
    if (d == 32'd0) begin
      push(2, n + 1, 32'd1, 32'd0);
    end else begin
      push(0, n + 1, busv(1'b1, 1'b0, 2'd1), 32'd0);
      push(0, n + 2, busv(1'b1, 1'b0, 2'd0), d);
      push(0, n + 3, busv(1'b1, 1'b0, 2'd1), 32'd1);
      push(2, n + 3, 32'd2, 32'd0);
      m_div = int'(d);
    end
    tick();
    cfg_start = 1'b0;
    cfg_div = $urandom;
    wait_until((d == 32'd0) ? n + 2 : n + 4);
  endtask

  task automatic run_tx(input int cnt, input bit v0, input bit v1);
    int t;
    int w;
    logic [7:0] b;
    t = cyc;
    req0_data = 8'($urandom);
    req1_data = 8'($urandom);
    req0_valid = v0;
    req1_valid = v1;
    for (int k = 0; k < cnt; k++) begin
      wait_until(t);
      if (v0 && v1) w = (m_last == 1) ? 0 : 1;
      else w = v0 ? 0 : 1;
      b = (w == 1) ? req1_data : req0_data;
      push(3, t, 32'(w), {24'd0, b});
      push(0, t + 1, busv(1'b1, 1'b0, 2'd2), {24'd0, b});
      m_last = w;
      tick();
      if (k == cnt - 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else if (w == 1) begin
        req1_data = 8'($urandom);
      end else begin
        req0_data = 8'($urandom);
      end
      t = t + 2 + 11 * m_div;
    end
    wait_until(t);
  endtask

  task automatic do_read(input logic [7:0] rx);
    int n;
    n = cyc;
    rd_req = 1'b1;
    rx_val = rx;
    push(0, n + 1, busv(1'b0, 1'b1, 2'd3), 32'd0);
    push(1, n + 3, 32'd0, {24'd0, rx});
    wait_until(n + 3);
    rd_req = 1'b0;
  endtask

  task automatic rd_over_tx(input logic [7:0] rx);
    int t;
    int r;
    logic [7:0] b2;
    t = cyc;
    req0_valid = 1'b1;
    req0_data = 8'($urandom);
    push(3, t, 32'd0, {24'd0, req0_data});
    push(0, t + 1, busv(1'b1, 1'b0, 2'd2), {24'd0, req0_data});
    m_last = 0;
    tick();
    b2 = 8'($urandom);
    req0_data = b2;
    wait_until(t + 5);
    chk("busy_in_hold", {63'd0, busy}, 64'd1);
    rd_req = 1'b1;
    rx_val = rx;
    r = t + 2 + 11 * m_div;
    push(0, r + 1, busv(1'b0, 1'b1, 2'd3), 32'd0);
    push(1, r + 3, 32'd0, {24'd0, rx});
    push(3, r + 3, 32'd0, {24'd0, b2});
    push(0, r + 4, busv(1'b1, 1'b0, 2'd2), {24'd0, b2});
    wait_until(r + 3);
    rd_req = 1'b0;
    tick();
    req0_valid = 1'b0;
    wait_until(r + 5 + 11 * m_div);
  endtask

  task automatic reset_mid_hold();
    int t;
    t = cyc;
    req0_valid = 1'b1;
    req0_data = 8'($urandom);
    push(3, t, 32'd0, {24'd0, req0_data});
    push(0, t + 1, busv(1'b1, 1'b0, 2'd2), {24'd0, req0_data});
    wait_until(t + 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = 1;
    @(negedge clk);
    chk("rst_mid_outs", {we, re, address, write_data, rd_valid, cfg_done, cfg_err,
                         cfg_ok, busy, req0_ready, req1_ready}, 64'd0);
    rd_req = 1'b1;
    repeat (20) tick();
    chk("unconfigured_idle", {cfg_ok, busy, req0_ready}, 64'd0);
    rd_req = 1'b0;
    do_cfg(32'($urandom_range(1, 3)));
    run_tx(1, 1'b1, 1'b0);
  endtask

  initial begin
    int m;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", {we, re, address, write_data, rd_valid, rd_data, cfg_done, cfg_err,
                       cfg_ok, busy, req0_ready, req1_ready}, 64'd0);
    tick();
    rst = 1'b0;

    req0_valid = 1'b1;
    req0_data = 8'($urandom);
    rd_req = 1'b1;
    repeat (10) tick();
    req0_valid = 1'b0;
    rd_req = 1'b0;
    tick();

    do_cfg(32'd0);
    chk("err_stays_idle", {busy, cfg_ok}, 64'd0);
    do_cfg(32'd5);
    chk("cfg_ok_set", {63'd0, cfg_ok}, 64'd1);
    run_tx(2, 1'b1, 1'b0);
    run_tx(5, 1'b1, 1'b1);
    do_cfg(32'd0);
    chk("cfg_ok_kept", {63'd0, cfg_ok}, 64'd1);
    rd_over_tx(8'h3C);

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_read(8'($urandom));
      end else begin
        m = $urandom_range(1, 3);
        run_tx($urandom_range(1, 3), m[0], m[1]);
      end
    end

    do_cfg(32'($urandom_range(1, 3)));
    chk("recfg_ok", {63'd0, cfg_ok}, 64'd1);
    run_tx(4, 1'b1, 1'b1);
    reset_mid_hold();

    repeat (5) tick();
    chk("bus_left", 64'(q_bus.size()), 64'd0);
    chk("rd_left", 64'(q_rd.size()), 64'd0);
    chk("ctl_left", 64'(q_ctl.size()), 64'd0);
    chk("acc_left", 64'(q_acc.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_host_ctrl.md
# uart_host_ctrl

Sequencer and arbiter that owns the `uart_top` register bus. It runs the configuration sequence (disable, baud divisor, enable), then shares the transmitter between two byte requesters with round-robin arbitration. It paces each byte by a frame-hold timer derived from the divisor, and services RX-register reads for a single reader. It sits between the system fabric and `uart_top`, driving its `address/write_data/we/re` ports.

## Interface
- No parameters; all widths are fixed by the `uart_top` register map.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_div` in 32: baud divisor to program; sampled when `cfg_start` is accepted.
- `cfg_start` in 1: request (re)configuration; one-cycle pulse.
- `cfg_done` out 1: one-cycle pulse when the enable write completes.
- `cfg_err` out 1: one-cycle pulse when `cfg_start` is rejected because `cfg_div==0`.
- `cfg_ok` out 1: level, high while configured and enabled.
- `req0_valid` / `req1_valid` in 1: requester has a TX byte.
- `req0_data` / `req1_data` in 8: TX byte.
- `req0_ready` / `req1_ready` out 1: byte accepted when `valid&ready`.
- `rd_req` in 1: request one RX-register read; held until `rd_valid`.
- `rd_data` out 8: RX byte.
- `rd_valid` out 1: one-cycle pulse, `rd_data` valid.
- `busy` out 1: high in every state except IDLE and READY.
- `address` out 2: to `uart_top` (0 baud, 1 enable, 2 tx_data, 3 rx_data).
- `write_data` out 32: to `uart_top`.
- `we` / `re` out 1: to `uart_top`.
- `read_data` in 8: from `uart_top`; valid one cycle after `re`.

## Operation
- States: IDLE, CFG_DIS, CFG_BAUD, CFG_EN, READY, TX_WR, TX_HOLD, RD_ISSUE, RD_CAP.
- **Configuration path**
  - IDLE: waits for `cfg_start`. If `cfg_div==0`, pulse `cfg_err` and stay in IDLE. Otherwise latch `cfg_div` and go to CFG_DIS.
  - CFG_DIS: `we=1`, addr 1, data 0.
  - CFG_BAUD: `we=1`, addr 0, data = latched div.
  - CFG_EN: `we=1`, addr 1, data 1. Pulse `cfg_done`, set `cfg_ok`, go to READY.
- **READY priority**
  1. `cfg_start`: go to CFG_DIS (or to `cfg_err` when div is 0, staying in READY with `cfg_ok` kept). `cfg_ok` clears on entry to CFG_DIS.
  2. `rd_req`: go to RD_ISSUE.
  3. TX arbitration.
- **TX arbitration (READY only)**
  - The grant is combinational. With one requester valid, it is granted. With both valid, the requester not granted last time wins.
  - `last_grant` resets to 1, so req0 wins the first tie.
  - `reqN_ready = (state==READY) & grantN & ~cfg_start & ~rd_req`.
  - On acceptance: capture the byte, update `last_grant`, go to TX_WR.
- TX_WR: `we=1`, addr 2, data = {24'b0, byte}. Load `hold_cnt = 11*div - 1` (36-bit product, counter 36 bits) and go to TX_HOLD.
- TX_HOLD: decrement `hold_cnt`; on 0 go to READY. `cfg_start` and `rd_req` stay pending and are served in READY afterward. The 11 bit-times are 10-bit frame plus 1 guard.
- RD_ISSUE: `re=1`, addr 3.
- RD_CAP: `rd_data <= read_data`, pulse `rd_valid`, go to READY.
- Idle bus: `we=re=0`, address 0, `write_data` 0.

## Timing
- Reset values: state IDLE; all outputs 0 (`address`, `write_data`, `we`, `re`, `rd_data`, `rd_valid`, all readies, `cfg_*`, `busy`).
- All bus outputs are registered. The exception is `reqN_ready`, which is combinational from state, grant and pending inputs.
- Configuration: `cfg_start` at cycle N gives `we` at N+1, N+2, N+3 (addr 1, 0, 1). `cfg_done` and `cfg_ok` are visible at N+3; READY is at N+4.
- TX: accept at cycle N gives the TX_WR `we` at N+1. TX_HOLD spans 11*div cycles (N+2 .. N+1+11*div). The next accept is possible at N+2+11*div.
- Read: `rd_req` seen in READY at N gives `re` at N+1 and `rd_valid` at N+3.
- Reset mid-operation: return to IDLE in one cycle, drop `cfg_ok`, abandon any hold count. `uart_top` is reset by the same `rst`.
- `rd_req` or TX requests while not `cfg_ok`: stay pending with no response.

## Structure
- Shared package `uart_pkg`:
  - register addresses `UART_ADDR_BAUD/ENABLE/TX/RX`;
  - the state enum;
  - `UART_FRAME_BITS = 11`.
- Sub-module `uart_rr_arb`: 2-way round-robin with `last_grant` register. Inputs are the valids and an advance strobe; outputs are the one-hot grant.

## Test plan
- Reset, then `cfg_start` with `cfg_div=5` → bus writes (1,0),(0,5),(1,1) on consecutive cycles; `cfg_done` pulses once; `cfg_ok=1`.
- `cfg_start` with `cfg_div=0` from IDLE → `cfg_err` pulse, no `we`, state stays IDLE.
- After config with div=5, req0 byte 0xA5 → `we` addr 2 data 0xA5. The next accept is exactly 2+55 cycles after the first.
- req0 and req1 both held valid with 0x11/0x22 → accepts alternate req0, req1, req0…, each separated by 57 cycles.
- `rd_req` while in TX_HOLD with the RX model providing 0x3C → no `re` until hold expires. Then `re` addr 3, and `rd_valid` with `rd_data=0x3C` 2 cycles later. `rd_req` wins over a simultaneous req0.
- `rst` asserted during TX_HOLD → next cycle all outputs 0, `cfg_ok=0`. req0 is not acknowledged until a new configuration completes.
